rr_stream_mux: RTL and testbench
================================

# rr_stream_mux

Parametrised N-input, WIDTH-bit valid/ready stream multiplexer with round-robin arbitration and a registered output stage. It replaces the fixed-select 2:1 data muxes when several producers share one downstream consumer under flow control. The block sits between producer channels and a single sink. It is the first mux in the `combinational/muxStuff` family to carry state: an arbitration pointer, an output register and an optional packet lock.

## Interface
- `WIDTH`, 8, data bits per channel.
- `N`, 4, number of input channels (2..16).
- `SEL_W`, `$clog2(N)`, width of the channel index (derived; not overridden).

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_data` input N*WIDTH: channel i occupies `[i*WIDTH +: WIDTH]`.
- `in_valid` input N: per-channel valid.
- `in_last` input N: per-channel end-of-packet marker. Ignored for arbitration unless the lock feature is compiled in.
- `in_ready` output N: per-channel ready; at most one bit is high.
- `out_data` output WIDTH: registered selected data.
- `out_last` output 1: registered `in_last` of the accepted beat.
- `out_sel` output SEL_W: index of the channel that produced the current output beat.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: sink accepts the beat.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `out_sel`=0. Internal pointer `ptr`=0 and `lock`=0.
- Output register is free when `!out_valid || out_ready`.
- Grant `g` is the first channel with `in_valid` high, searching `ptr, ptr+1, …, N-1, 0, …` (mod N). There is no grant when no `in_valid` bit is high.
- `in_ready[g]` = register free. All other `in_ready` bits are 0. `in_ready` may depend combinationally on `in_valid` and `out_ready`.
- Input transfer happens when `in_valid[g] && in_ready[g]`. On transfer: `out_data`←channel g data, `out_last`←`in_last[g]`, `out_sel`←g, `out_valid`←1, `ptr`←(g+1) mod N (wrap from N-1 to 0).
- Output transfer without a new input transfer: `out_valid`←0, other outputs hold.
- Simultaneous output and input transfer in the same cycle: the register reloads. Throughput is 1 beat/cycle.
- While `out_valid && !out_ready`: register, `ptr` and `in_ready` (all 0) hold.
- Producers must hold `in_data`/`in_last` stable while valid and not ready. The mux does not check this.
- `reset` mid-stream: the beat in the output register is discarded and all state returns to reset values on the next edge.

## Timing
- Latency: input transfer at edge k → `out_valid`=1 with that beat after edge k.
- `out_*` are all flop outputs. The only combinational paths are `in_valid`/`out_ready` → `in_ready`.
- Fairness: with all N channels valid continuously and `out_ready`=1, grants cycle 0,1,…,N-1,0,… with no channel starved for more than N-1 beats.

## Configuration
- `RR_STREAM_MUX_LOCK_EN` defined: packet lock.
  - A transfer with `in_last[g]`=0 sets `lock`=1 and freezes the grant on g. `ptr` does not advance.
  - While locked, only channel g can be ready, even if g drops valid.
  - A transfer with `in_last[g]`=1 clears `lock` and sets `ptr`←(g+1) mod N.
  - `reset` clears `lock`.
- Macro undefined: arbitration every beat as above. `in_last` is passed through to `out_last` only, and the `lock` flop is absent.

## Structure
- Package `rr_stream_mux_pkg`: default `WIDTH`/`N` constants and a `logic [SEL_W-1:0]`-sized index typedef helper. No state enum is needed; the lock is a single flop.
- One sub-module: `rr_arbiter` (`N` parameter; inputs `req`, `ptr`; outputs one-hot `gnt`, binary `gnt_idx`, `any`), purely combinational.
- The top holds the pointer, the lock and the output register.

## Test plan
- Reset, then all inputs idle: `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=0000.
- N=4, only channel 2 valid with data 0xA5, `out_ready`=1: `in_ready`=0100; next cycle `out_data`=0xA5, `out_sel`=2.
- All 4 channels valid continuously, `out_ready`=1: `out_sel` sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
- Beat held with `out_ready`=0 for 3 cycles while all channels are valid: `out_data` is stable and `in_ready`=0000. On release, the next grant is (held `out_sel`+1) mod 4.
- With `RR_STREAM_MUX_LOCK_EN`, channel 1 sends 3 beats (last on the third) while channel 0 is valid throughout: `out_sel`=1,1,1, then 0.
- Assert `reset` while `out_valid`=1 and `out_ready`=0: next cycle `out_valid`=0, and the next grant starts search from channel 0.

Source files
------------

// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream mux.
package rr_stream_mux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_N     = 4;
    localparam int unsigned DEFAULT_SEL_W = $clog2(DEFAULT_N);

    // Channel index for the default configuration
    typedef logic [DEFAULT_SEL_W-1:0] idx_t;

    // Next channel index after idx, wrapping from n-1 back to 0
    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Producer/sink bundle for rr_stream_mux. The mux side uses modport slave,
// the environment (producers and sink) uses modport master.
interface rr_stream_mux_if
    import rr_stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned N     = DEFAULT_N
);
    localparam int unsigned SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_last, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_last, out_sel, out_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, mod N.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    // Scan from farthest to nearest so the channel closest to ptr wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int off = int'(N) - 1; off >= 0; off--) begin
            if (req[SEL_W'((int'(ptr) + off) % int'(N))]) begin
                gnt                                         = '0;
                gnt[SEL_W'((int'(ptr) + off) % int'(N))]    = 1'b1;
                gnt_idx                                     = SEL_W'((int'(ptr) + off) % int'(N));
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_stream_mux.sv
// N-input valid/ready stream mux with round-robin arbitration and a
// registered output stage. Define RR_STREAM_MUX_LOCK_EN to hold the grant
// on one channel from the first beat of a packet until its last beat.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned N     = DEFAULT_N
) (
    input  logic          clk,
    input  logic          reset,
    rr_stream_mux_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(N);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
`ifdef RR_STREAM_MUX_LOCK_EN
    logic             lock_q, lock_d;
`endif

    logic [N-1:0]     arb_gnt;
    logic [SEL_W-1:0] arb_idx;
    logic             arb_any;
    logic             free;
    logic             have;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     gnt_vec;
    logic             xfer;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Grant selection, ready generation and next-state of the output stage
    always_comb begin
        free = !out_valid_q || bus.out_ready;
`ifdef RR_STREAM_MUX_LOCK_EN
        // While locked the previous winner (still in out_sel) keeps the grant
        sel     = lock_q ? out_sel_q : arb_idx;
        have    = lock_q || arb_any;
        gnt_vec = lock_q ? (N'(1) << out_sel_q) : arb_gnt;
`else
        sel     = arb_idx;
        have    = arb_any;
        gnt_vec = arb_gnt;
`endif
        xfer = have && free && bus.in_valid[sel];

        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
`ifdef RR_STREAM_MUX_LOCK_EN
        lock_d      = lock_q;
`endif
        if (xfer) begin
            out_data_d  = bus.in_data[sel*WIDTH +: WIDTH];
            out_last_d  = bus.in_last[sel];
            out_sel_d   = sel;
            out_valid_d = 1'b1;
`ifdef RR_STREAM_MUX_LOCK_EN
            if (bus.in_last[sel]) begin
                lock_d = 1'b0;
                ptr_d  = SEL_W'(wrap_inc(int'(sel), N));
            end else begin
                lock_d = 1'b1;
            end
`else
            ptr_d = SEL_W'(wrap_inc(int'(sel), N));
`endif
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef RR_STREAM_MUX_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
`ifdef RR_STREAM_MUX_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign bus.in_ready  = free ? gnt_vec : '0;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed self-checking bench for rr_stream_mux (N=4, WIDTH=8).
module tb_rr_stream_mux;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    rr_stream_mux_if #(.WIDTH(8), .N(4)) bus ();

    rr_stream_mux #(
        .WIDTH (8),
        .N     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.in_data    = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.in_valid   = 4'b0000;
        bus.in_last    = 4'b0000;
        bus.out_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state, idle inputs
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data),  32'h00);
        chk("rst_sel",   32'(bus.out_sel),   32'd0);
        chk("rst_last",  32'(bus.out_last),  32'd0);
        chk("rst_ready", 32'(bus.in_ready),  32'b0000);

        // Only channel 2 valid, carrying 0xA5 with last set
        bus.out_ready = 1'b1;
        bus.in_data   = {8'h13, 8'hA5, 8'h11, 8'h10};
        bus.in_valid  = 4'b0100;
        bus.in_last   = 4'b0100;
        #1;
        chk("ch2_ready", 32'(bus.in_ready), 32'b0100);
        step();
        chk("ch2_valid", 32'(bus.out_valid), 32'd1);
        chk("ch2_data",  32'(bus.out_data),  32'hA5);
        chk("ch2_sel",   32'(bus.out_sel),   32'd2);
        chk("ch2_last",  32'(bus.out_last),  32'd1);

        // Output drains with no new input: valid drops, other outputs hold
        bus.in_valid = 4'b0000;
        bus.in_last  = 4'b0000;
        step();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_sel",   32'(bus.out_sel),   32'd2);
        chk("drain_data",  32'(bus.out_data),  32'hA5);

        // Restart from pointer 0, all channels valid continuously
        reset = 1'b1;
        step();
        reset        = 1'b0;
        bus.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.in_valid = 4'b1111;
        #1;
        chk("rr_ready0", 32'(bus.in_ready), 32'b0001);
        step();
        chk("rr_sel0",  32'(bus.out_sel),   32'd0);
        chk("rr_data0", 32'(bus.out_data),  32'h10);
        chk("rr_ready1", 32'(bus.in_ready), 32'b0010);
        step();
        chk("rr_sel1",  32'(bus.out_sel),   32'd1);
        chk("rr_data1", 32'(bus.out_data),  32'h11);
        step();
        chk("rr_sel2",  32'(bus.out_sel),   32'd2);
        chk("rr_data2", 32'(bus.out_data),  32'h12);
        step();
        chk("rr_sel3",  32'(bus.out_sel),   32'd3);
        chk("rr_data3", 32'(bus.out_data),  32'h13);
        chk("rr_wrap_ready", 32'(bus.in_ready), 32'b0001);
        step();
        chk("rr_sel4",   32'(bus.out_sel),   32'd0);
        chk("rr_valid4", 32'(bus.out_valid), 32'd1);

        // Backpressure for 3 cycles: beat and pointer hold, nothing ready
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", 32'(bus.in_ready),  32'b0000);
            step();
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data",  32'(bus.out_data),  32'h10);
            chk("hold_sel",   32'(bus.out_sel),   32'd0);
        end
        // Release: next grant is held sel + 1, with simultaneous reload
        bus.out_ready = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.in_ready), 32'b0010);
        step();
        chk("rel_sel",   32'(bus.out_sel),   32'd1);
        chk("rel_data",  32'(bus.out_data),  32'h11);
        chk("rel_valid", 32'(bus.out_valid), 32'd1);

        // Reset while a beat is stalled: beat discarded, search restarts at 0
        bus.out_ready = 1'b0;
        step();
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data",  32'(bus.out_data),  32'h00);
        chk("mid_rst_sel",   32'(bus.out_sel),   32'd0);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'b0001);
        step();
        chk("post_rst_sel", 32'(bus.out_sel), 32'd0);

`ifdef RR_STREAM_MUX_LOCK_EN
        // Packet lock: ch0 single-beat packet moves ptr to 1, then ch1 sends
        // a 3-beat packet while ch0 stays valid
        reset = 1'b1;
        step();
        reset        = 1'b0;
        bus.in_valid = 4'b0001;
        bus.in_last  = 4'b0001;
        step();
        chk("lk_sel_a", 32'(bus.out_sel), 32'd0);
        bus.in_valid = 4'b0011;
        bus.in_last  = 4'b0000;
        #1;
        chk("lk_ready_a", 32'(bus.in_ready), 32'b0010);
        step();
        chk("lk_sel_b", 32'(bus.out_sel), 32'd1);
        chk("lk_ready_b", 32'(bus.in_ready), 32'b0010);
        step();
        chk("lk_sel_c", 32'(bus.out_sel), 32'd1);
        bus.in_last = 4'b0010;
        step();
        chk("lk_sel_d",  32'(bus.out_sel),  32'd1);
        chk("lk_last_d", 32'(bus.out_last), 32'd1);
        bus.in_valid = 4'b0001;
        bus.in_last  = 4'b0001;
        step();
        chk("lk_sel_e", 32'(bus.out_sel), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
